// File: rtl/subleq_core.sv
// Parametrised SUBLEQ core: fetch a/b/c, read mem[a] and mem[b], write mem[b]-mem[a], branch if <= 0.
// Optional build macro SUBLEQ_MMIO_EN maps the all-ones address to the io_out register.
module subleq_core #(
    parameter int                WORD_SIZE = 16,
    parameter int                ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int                CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 run,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    input  logic                 mem_ack,
    output logic [ADDR_W-1:0]    pc,
    output logic                 halted,
    output logic [CNT_W-1:0]     insn_count
`ifdef SUBLEQ_MMIO_EN
    ,
    output logic [WORD_SIZE-1:0] io_out
`endif
);

    typedef enum logic [2:0] {
        S_IDLE, S_FA, S_FB, S_FC, S_RA, S_RB, S_WB, S_HALT
    } state_t;

    function automatic logic branch_taken(input logic [WORD_SIZE-1:0] r);
        return (r == '0) || r[WORD_SIZE-1];
    endfunction

    function automatic logic word_all_ones(input logic [WORD_SIZE-1:0] w);
        return w == {WORD_SIZE{1'b1}};
    endfunction

    function automatic logic addr_all_ones(input logic [ADDR_W-1:0] a);
        return a == {ADDR_W{1'b1}};
    endfunction

    state_t                state_q, state_d;
    logic                  ph_q, ph_d;
    logic [ADDR_W-1:0]     pc_q, pc_d;
    logic                  halted_q, halted_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
`ifdef SUBLEQ_MMIO_EN
    logic [WORD_SIZE-1:0]  io_q, io_d;
`endif

    logic [ADDR_W-1:0]     a_q, a_d;
    logic [ADDR_W-1:0]     b_q, b_d;
    logic [WORD_SIZE-1:0]  c_q, c_d;
    logic [WORD_SIZE-1:0]  ma_q, ma_d;
    logic [WORD_SIZE-1:0]  mb_q, mb_d;

    logic [WORD_SIZE-1:0]  r;
    logic [ADDR_W-1:0]     acc_addr;
    logic                  is_acc;
    logic                  bypass;
    logic                  done;

    assign r = mb_q - ma_q;

    always_comb begin
        state_d  = state_q;
        ph_d     = ph_q;
        pc_d     = pc_q;
        halted_d = halted_q;
        cnt_d    = cnt_q;
`ifdef SUBLEQ_MMIO_EN
        io_d     = io_q;
`endif
        a_d      = a_q;
        b_d      = b_q;
        c_d      = c_q;
        ma_d     = ma_q;
        mb_d     = mb_q;
        acc_addr = '0;
        is_acc   = 1'b0;
        bypass   = 1'b0;

        unique case (state_q)
            S_FA: begin is_acc = 1'b1; acc_addr = pc_q; end
            S_FB: begin is_acc = 1'b1; acc_addr = pc_q + ADDR_W'(1); end
            S_FC: begin is_acc = 1'b1; acc_addr = pc_q + ADDR_W'(2); end
            S_RA: begin is_acc = 1'b1; acc_addr = a_q; end
            S_RB: begin is_acc = 1'b1; acc_addr = b_q; end
            S_WB: begin is_acc = 1'b1; acc_addr = b_q; end
            default: ;
        endcase

`ifdef SUBLEQ_MMIO_EN
        // Data accesses to the all-ones address never reach memory; fetches do.
        if ((state_q == S_RA || state_q == S_RB || state_q == S_WB) && addr_all_ones(acc_addr))
            bypass = 1'b1;
`endif

        done = is_acc && (bypass || (ph_q && mem_ack));

        // ph_q=0 is the idle gap cycle before each request is raised.
        if (is_acc && !bypass && !ph_q)
            ph_d = 1'b1;

        if (state_q == S_IDLE && run && !halted_q) begin
            state_d = S_FA;
            ph_d    = 1'b0;
        end

        if (done) begin
            ph_d = 1'b0;
            unique case (state_q)
                S_FA: begin a_d = mem_rdata[ADDR_W-1:0]; state_d = S_FB; end
                S_FB: begin b_d = mem_rdata[ADDR_W-1:0]; state_d = S_FC; end
                S_FC: begin c_d = mem_rdata;             state_d = S_RA; end
                S_RA: begin ma_d = bypass ? '0 : mem_rdata; state_d = S_RB; end
                S_RB: begin mb_d = bypass ? '0 : mem_rdata; state_d = S_WB; end
                S_WB: begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = S_IDLE;
`ifdef SUBLEQ_MMIO_EN
                    if (bypass)
                        io_d = r;
`endif
                    if (branch_taken(r)) begin
                        if (word_all_ones(c_q)) begin
                            halted_d = 1'b1;
                            state_d  = S_HALT;
                        end else begin
                            pc_d = c_q[ADDR_W-1:0];
                        end
                    end else begin
                        pc_d = pc_q + ADDR_W'(3);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            ph_q     <= 1'b0;
            pc_q     <= RESET_PC;
            halted_q <= 1'b0;
            cnt_q    <= '0;
`ifdef SUBLEQ_MMIO_EN
            io_q     <= '0;
`endif
        end else begin
            state_q  <= state_d;
            ph_q     <= ph_d;
            pc_q     <= pc_d;
            halted_q <= halted_d;
            cnt_q    <= cnt_d;
`ifdef SUBLEQ_MMIO_EN
            io_q     <= io_d;
`endif
        end
    end

    // Operand registers are only read in states they were loaded for, so they need no reset.
    always_ff @(posedge clk) begin
        a_q  <= a_d;
        b_q  <= b_d;
        c_q  <= c_d;
        ma_q <= ma_d;
        mb_q <= mb_d;
    end

    assign mem_req    = is_acc && !bypass && ph_q;
    assign mem_we     = is_acc && (state_q == S_WB);
    assign mem_addr   = acc_addr;
    assign mem_wdata  = (state_q == S_WB) ? r : '0;
    assign pc         = pc_q;
    assign halted     = halted_q;
    assign insn_count = cnt_q;
`ifdef SUBLEQ_MMIO_EN
    assign io_out     = io_q;
`endif

endmodule
